pc_fetch_unit: RTL

Program-counter and instruction-fetch stage that sits directly upstream of register_file. It holds the architectural PC and runs a req/ack fetch handshake with instruction memory. It issues one instruction at a time to decode. It drives the register file's r15 input with PC+8, using ARM-style read-ahead.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_next_sel.sv | 21 ++
 rtl/pc_fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_AHEAD_DEFAULT = 8;
    localparam int          WORD_BYTES       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-pc selection: word-aligned branch target or sequential pc+4
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] pc_next
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

    assign pc_plus4 = pc + STEP;
    // Masking keeps every target bit in the expression while forcing word alignment.
    assign pc_next  = branch_taken ? (branch_target & ALIGN_MASK) : pc_plus4;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and req/ack instruction fetch stage
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                PC_AHEAD = PC_AHEAD_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] r15
);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic              imem_req_q;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_d)
    );

    // Outputs are registered alongside the state so they never glitch on input changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_q          <= pc_d;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        state_q       <= REQ;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign imem_req    = imem_req_q;
    assign r15         = pc_q + ADDR_W'(PC_AHEAD);

endmodule
